// File: rtl/motion_pkg.sv
// Shared motion-control definitions: PWM generator state encoding and default width.
package motion_pkg;

  // PWM generator control states: stopped, counting, and finishing the last period.
  typedef enum logic [1:0] {
    PWM_IDLE  = 2'd0,
    PWM_RUN   = 2'd1,
    PWM_DRAIN = 2'd2
  } pwm_state_t;

  localparam int PWM_WIDTH_DEFAULT = 16;

endpackage : motion_pkg

// File: rtl/pwm_gen.sv
// Single-channel PWM generator driven by a one-cycle prescale strobe.
// Period and on-time are double-buffered so changes only land on a period
// boundary, and stopping always finishes the current period (no runt pulses).
module pwm_gen
  import motion_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             tick,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] on_time_in,
  output logic             pwm_out,
  output logic             period_end,
  output logic             running
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);

  // Output level for a given counter position; on_time >= period saturates to 100%.
  function automatic logic pwm_level(input logic             run,
                                     input logic [WIDTH-1:0] cnt,
                                     input logic [WIDTH-1:0] on_time);
    return run && (cnt < on_time);
  endfunction

  pwm_state_t       state_r, state_s;
  logic [WIDTH-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] act_period_r, act_period_s;
  logic [WIDTH-1:0] act_on_r, act_on_s;
  logic [WIDTH-1:0] pend_period_r, pend_period_s;
  logic [WIDTH-1:0] pend_on_r, pend_on_s;
  logic             pend_valid_r, pend_valid_s;
  logic             counting_s;
  logic             last_s;
  logic             wrap_s;
  logic             running_s;

  // Detect the count step that closes the current period.
  always_comb begin
    counting_s = 1'b0;
    last_s     = 1'b0;
    wrap_s     = 1'b0;
    if (state_r != PWM_IDLE) begin
      counting_s = tick;
      last_s     = (cnt_r == (act_period_r - CNT_ONE));
      wrap_s     = counting_s && last_s;
    end else begin
      counting_s = 1'b0;
      last_s     = 1'b0;
      wrap_s     = 1'b0;
    end
  end

  // Active/pending register updates: direct load when idle, buffered load while running.
  always_comb begin
    act_period_s  = act_period_r;
    act_on_s      = act_on_r;
    pend_period_s = pend_period_r;
    pend_on_s     = pend_on_r;
    pend_valid_s  = pend_valid_r;
    case (state_r)
      PWM_IDLE: begin
        if (load) begin
          act_period_s = period_in;
          act_on_s     = on_time_in;
        end else begin
          act_period_s = act_period_r;
          act_on_s     = act_on_r;
        end
      end
      PWM_RUN, PWM_DRAIN: begin
        // The wrap consumes the pending contents as they were before this edge,
        // so a load landing on the wrap edge is held for the following wrap.
        if (wrap_s && pend_valid_r) begin
          act_period_s = pend_period_r;
          act_on_s     = pend_on_r;
        end else begin
          act_period_s = act_period_r;
          act_on_s     = act_on_r;
        end
        if (load) begin
          pend_period_s = period_in;
          pend_on_s     = on_time_in;
          pend_valid_s  = 1'b1;
        end else if (wrap_s && pend_valid_r) begin
          pend_valid_s  = 1'b0;
        end else begin
          pend_valid_s  = pend_valid_r;
        end
      end
      default: begin
        act_period_s  = act_period_r;
        act_on_s      = act_on_r;
        pend_period_s = pend_period_r;
        pend_on_s     = pend_on_r;
        pend_valid_s  = pend_valid_r;
      end
    endcase
  end

  // Next state and counter; a zero period can never be entered or kept running.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      PWM_IDLE: begin
        // act_period_s already reflects an idle load on this edge.
        if (enable && (act_period_s != CNT_ZERO)) begin
          state_s = PWM_RUN;
        end else begin
          state_s = PWM_IDLE;
        end
      end
      PWM_RUN: begin
        if (wrap_s && (act_period_s == CNT_ZERO)) begin
          state_s = PWM_IDLE;
        end else if (!enable) begin
          state_s = PWM_DRAIN;
        end else begin
          state_s = PWM_RUN;
        end
      end
      PWM_DRAIN: begin
        if (wrap_s && ((act_period_s == CNT_ZERO) || !enable)) begin
          state_s = PWM_IDLE;
        end else if (enable) begin
          state_s = PWM_RUN;
        end else begin
          state_s = PWM_DRAIN;
        end
      end
      default: begin
        state_s = PWM_IDLE;
      end
    endcase

    if (state_s == PWM_IDLE) begin
      cnt_s = CNT_ZERO;
    end else if (counting_s) begin
      if (last_s) begin
        cnt_s = CNT_ZERO;
      end else begin
        cnt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_s = cnt_r;
    end

    running_s = (state_s != PWM_IDLE);
  end

  // State, buffers and registered outputs; reset aborts any period immediately.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_r       <= PWM_IDLE;
      cnt_r         <= CNT_ZERO;
      act_period_r  <= CNT_ZERO;
      act_on_r      <= CNT_ZERO;
      pend_period_r <= CNT_ZERO;
      pend_on_r     <= CNT_ZERO;
      pend_valid_r  <= 1'b0;
      pwm_out       <= 1'b0;
      period_end    <= 1'b0;
      running       <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      act_period_r  <= act_period_s;
      act_on_r      <= act_on_s;
      pend_period_r <= pend_period_s;
      pend_on_r     <= pend_on_s;
      pend_valid_r  <= pend_valid_s;
      pwm_out       <= pwm_level(running_s, cnt_s, act_on_s);
      period_end    <= wrap_s;
      running       <= running_s;
    end
  end

endmodule : pwm_gen

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: table of period/on-time vectors plus
// hand-written sequences for buffering, wrap-edge load, drain, extremes and reset.
module tb_pwm_gen;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] period_in = 16'd0;
  logic [15:0] on_time_in = 16'd0;
  logic        pwm_out;
  logic        period_end;
  logic        running;

  logic [1:0]  div = 2'd0;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic [15:0] p;
    logic [15:0] o;
    int          exp_len;
    int          exp_hi;
  } vec_t;

  vec_t vecs [7];

  pwm_gen #(.WIDTH(16)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .tick       (tick),
    .enable     (enable),
    .load       (load),
    .period_in  (period_in),
    .on_time_in (on_time_in),
    .pwm_out    (pwm_out),
    .period_end (period_end),
    .running    (running)
  );

  always #10 clk_in = ~clk_in;

  // Prescale model: one-cycle tick every 4 clk_in, changed on the falling edge.
  always @(negedge clk_in) begin
    div  <= div + 2'd1;
    tick <= (div == 2'd3);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start(input logic [15:0] p, input logic [15:0] o);
    reset = 1'b1;
    enable = 1'b0;
    load = 1'b0;
    step(2);
    reset = 1'b0;
    period_in = p;
    on_time_in = o;
    load = 1'b1;
    step(1);
    load = 1'b0;
    enable = 1'b1;
    step(1);
  endtask

  task automatic wait_pe(input string name);
    int n;
    n = 0;
    while (!period_end && n < 500) begin
      step(1);
      n++;
    end
    check(name, int'(period_end), 1);
  endtask

  // Starting on a period_end sample, count clk_in cycles and high cycles up to
  // the next period_end; optionally pulse load or drop enable at a sample index.
  task automatic measure(input int load_at, input logic [15:0] lp, input logic [15:0] lo,
                         input int en_at, output int len, output int hi, output int run_all);
    len = 0;
    hi = 0;
    run_all = 1;
    do begin
      if (pwm_out) hi++;
      if (!running) run_all = 0;
      if (len == load_at) begin
        period_in = lp;
        on_time_in = lo;
        load = 1'b1;
      end
      if (len == en_at) enable = 1'b0;
      len++;
      step(1);
      load = 1'b0;
    end while (!period_end && len < 2000);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int len, hi, ra, pe_seen;

    vecs[0] = '{p: 16'd10, o: 16'd3,  exp_len: 40, exp_hi: 12};
    vecs[1] = '{p: 16'd10, o: 16'd7,  exp_len: 40, exp_hi: 28};
    vecs[2] = '{p: 16'd8,  o: 16'd2,  exp_len: 32, exp_hi: 8};
    vecs[3] = '{p: 16'd5,  o: 16'd0,  exp_len: 20, exp_hi: 0};
    vecs[4] = '{p: 16'd10, o: 16'd12, exp_len: 40, exp_hi: 40};
    vecs[5] = '{p: 16'd1,  o: 16'd1,  exp_len: 4,  exp_hi: 4};
    vecs[6] = '{p: 16'd4,  o: 16'd4,  exp_len: 16, exp_hi: 16};

    // Reset state.
    step(3);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_pe", int'(period_end), 0);
    check("reset_running", int'(running), 0);
    reset = 1'b0;
    enable = 1'b1;
    step(6);
    check("idle_no_period_running", int'(running), 0);
    enable = 1'b0;

    // Table-driven steady-state periods.
    for (int i = 0; i < 7; i++) begin
      start(vecs[i].p, vecs[i].o);
      wait_pe($sformatf("vec%0d_first_wrap", i));
      measure(-1, 16'd0, 16'd0, -1, len, hi, ra);
      check($sformatf("vec%0d_len", i), len, vecs[i].exp_len);
      check($sformatf("vec%0d_high", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_running", i), ra, 1);
    end

    // Double-buffer: mid-period load only affects the next period.
    start(16'd10, 16'd3);
    wait_pe("dbuf_first_wrap");
    measure(8, 16'd10, 16'd7, -1, len, hi, ra);
    check("dbuf_cur_len", len, 40);
    check("dbuf_cur_high", hi, 12);
    measure(-1, 16'd0, 16'd0, -1, len, hi, ra);
    check("dbuf_next_len", len, 40);
    check("dbuf_next_high", hi, 28);

    // Load coincident with the wrap edge is deferred by one more period.
    start(16'd10, 16'd3);
    wait_pe("wrapload_first_wrap");
    measure(39, 16'd8, 16'd2, -1, len, hi, ra);
    check("wrapload_p0_len", len, 40);
    check("wrapload_p0_high", hi, 12);
    measure(-1, 16'd0, 16'd0, -1, len, hi, ra);
    check("wrapload_p1_len", len, 40);
    check("wrapload_p1_high", hi, 12);
    measure(-1, 16'd0, 16'd0, -1, len, hi, ra);
    check("wrapload_p2_len", len, 32);
    check("wrapload_p2_high", hi, 8);

    // Drain: drop enable around cnt=4, period completes, then idle.
    start(16'd10, 16'd3);
    wait_pe("drain_first_wrap");
    measure(-1, 16'd0, 16'd0, 18, len, hi, ra);
    check("drain_len", len, 40);
    check("drain_high", hi, 12);
    check("drain_running_during", ra, 1);
    check("drain_wrap_pe", int'(period_end), 1);
    check("drain_after_running", int'(running), 0);
    check("drain_after_pwm", int'(pwm_out), 0);
    step(1);
    check("drain_pe_one_cycle", int'(period_end), 0);
    step(10);
    check("drain_idle_running", int'(running), 0);
    check("drain_idle_pwm", int'(pwm_out), 0);

    // Zero period with enable held: stays idle.
    start(16'd0, 16'd5);
    pe_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (period_end || running || pwm_out) pe_seen++;
      step(1);
    end
    check("zero_period_activity", pe_seen, 0);
    check("zero_period_running", int'(running), 0);

    // Reset during a high phase, then no restart until a load.
    start(16'd10, 16'd7);
    wait_pe("rst_first_wrap");
    step(21);
    check("rst_pre_pwm_high", int'(pwm_out), 1);
    reset = 1'b1;
    step(1);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_running", int'(running), 0);
    check("rst_pe", int'(period_end), 0);
    reset = 1'b0;
    pe_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (running || pwm_out) pe_seen++;
      step(1);
    end
    check("rst_stays_idle", pe_seen, 0);
    period_in = 16'd10;
    on_time_in = 16'd3;
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    check("rst_reload_running", int'(running), 1);
    wait_pe("rst_reload_wrap");
    measure(-1, 16'd0, 16'd0, -1, len, hi, ra);
    check("rst_reload_len", len, 40);
    check("rst_reload_high", hi, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pwm_gen
